// File: rtl/cpu_if.sv
// rtl/cpu_if.sv - control, program-load, immediate and flag bundle for the cpu block
interface cpu_if #(
    parameter int DATA_W = 12
);
    logic              en;
    logic              we_IM;
    logic [31:0]       codein;
    logic [DATA_W-1:0] immd;
    logic              za;
    logic              zb;
    logic              eq;
    logic              gt;
    logic              lt;

    modport master (
        output en, we_IM, codein, immd,
        input  za, zb, eq, gt, lt
    );

    modport slave (
        input  en, we_IM, codein, immd,
        output za, zb, eq, gt, lt
    );
endinterface

// File: rtl/cpu.sv
// rtl/cpu.sv - single-cycle 12-bit cpu with streamed instruction memory and registered flags
module cpu #(
    parameter int DATA_W   = 12,
    parameter int IM_DEPTH = 16,
    parameter int NREGS    = 16
) (
    input  logic clk,
    input  logic rst,
    cpu_if.slave bus
);
    localparam int PC_W = $clog2(IM_DEPTH);

    logic [31:0]       im   [IM_DEPTH];
    logic [DATA_W-1:0] regs [NREGS];
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   wp;
    logic [4:0]        flags_q;

    logic [15:0]       instr;
    logic [3:0]        op;
    logic [3:0]        rd;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu_res;
    logic              wr_en;
    logic              flag_upd;
    logic [PC_W-1:0]   pc_next;
    logic [4:0]        flag_next;

    // Upper half of each stored word is kept but never decoded.
    assign instr = im[pc][15:0];
    assign op    = instr[15:12];
    assign rd    = instr[11:8];
    assign ra    = instr[7:4];
    assign rb    = instr[3:0];
    assign a     = regs[ra];
    assign b     = regs[rb];

    assign flag_next = {a == '0, b == '0, a == b, a > b, a < b};

    always_comb begin
        alu_res  = '0;
        wr_en    = 1'b0;
        flag_upd = 1'b0;
        pc_next  = pc + 1'b1;
        case (op)
            4'h1: begin alu_res = a + b;              wr_en = 1'b1; flag_upd = 1'b1; end
            4'h2: begin alu_res = a - b;              wr_en = 1'b1; flag_upd = 1'b1; end
            4'h3: begin alu_res = a & b;              wr_en = 1'b1; flag_upd = 1'b1; end
            4'h4: begin alu_res = a | b;              wr_en = 1'b1; flag_upd = 1'b1; end
            4'h5: begin alu_res = a ^ b;              wr_en = 1'b1; flag_upd = 1'b1; end
            4'h6: flag_upd = 1'b1;
            4'h7: begin alu_res = bus.immd;           wr_en = 1'b1; end
            4'h8: begin alu_res = a;                  wr_en = 1'b1; flag_upd = 1'b1; end
            4'h9: begin alu_res = a << 1;             wr_en = 1'b1; flag_upd = 1'b1; end
            4'hA: begin alu_res = a >> 1;             wr_en = 1'b1; flag_upd = 1'b1; end
            4'hB: begin alu_res = ~a;                 wr_en = 1'b1; flag_upd = 1'b1; end
            4'hC: pc_next = instr[PC_W-1:0];
            // Branch looks at the flags as they stand before this edge.
            4'hD: if (flags_q[2]) pc_next = instr[PC_W-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            wp      <= '0;
            flags_q <= '0;
            for (int i = 0; i < NREGS; i++)    regs[i] <= '0;
            for (int i = 0; i < IM_DEPTH; i++) im[i]   <= '0;
        end else if (bus.we_IM) begin
            // Program loading always wins over execution in the same cycle.
            im[wp] <= bus.codein;
            wp     <= wp + 1'b1;
        end else if (bus.en) begin
            pc <= pc_next;
            if (wr_en)    regs[rd] <= alu_res;
            if (flag_upd) flags_q  <= flag_next;
        end
    end

    assign bus.za = flags_q[4];
    assign bus.zb = flags_q[3];
    assign bus.eq = flags_q[2];
    assign bus.gt = flags_q[1];
    assign bus.lt = flags_q[0];
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - scoreboard bench for cpu against an arithmetic reference model
module tb_cpu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_if #(.DATA_W(12)) bus ();

    cpu #(.DATA_W(12), .IM_DEPTH(16), .NREGS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [4:0] exp;
        bit         has_k;
        logic [4:0] k;
        string      name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, arithmetic mod 4096.
    logic [31:0] im_m [16];
    int          regs_m [16];
    int          pc_m, wp_m;
    logic [4:0]  fl_m;

    task automatic model_edge(input logic r, input logic en, input logic we,
                              input logic [31:0] code, input logic [11:0] imm);
        int op, rd, ra, rb, va, vb, res, npc;
        bit wr, upd;
        if (r) begin
            pc_m = 0; wp_m = 0; fl_m = 5'b0;
            for (int i = 0; i < 16; i++) begin regs_m[i] = 0; im_m[i] = 32'h0; end
        end else if (we) begin
            im_m[wp_m] = code;
            wp_m = (wp_m + 1) % 16;
        end else if (en) begin
            op = int'(im_m[pc_m][15:12]);
            rd = int'(im_m[pc_m][11:8]);
            ra = int'(im_m[pc_m][7:4]);
            rb = int'(im_m[pc_m][3:0]);
            va = regs_m[ra];
            vb = regs_m[rb];
            npc = (pc_m + 1) % 16;
            wr = 0; upd = 1; res = 0;
            case (op)
                1:  begin res = (va + vb) % 4096;        wr = 1; end
                2:  begin res = (va - vb + 4096) % 4096; wr = 1; end
                3:  begin res = va & vb;                 wr = 1; end
                4:  begin res = va | vb;                 wr = 1; end
                5:  begin res = va ^ vb;                 wr = 1; end
                6:  ;
                7:  begin res = int'(imm); wr = 1; upd = 0; end
                8:  begin res = va;                      wr = 1; end
                9:  begin res = (va * 2) % 4096;         wr = 1; end
                10: begin res = va / 2;                  wr = 1; end
                11: begin res = 4095 - va;               wr = 1; end
                12: begin npc = rb; upd = 0; end
                13: begin if (fl_m[2]) npc = rb; upd = 0; end
                default: upd = 0;
            endcase
            if (upd) fl_m = {va == 0, vb == 0, va == vb, va > vb, va < vb};
            if (wr) regs_m[rd] = res;
            pc_m = npc;
        end
    endtask

    // Advance one edge, apply it to the model, enqueue the expected flags.
    task automatic tick(input string name, input bit use_k, input logic [4:0] k);
        sb_entry_t e;
        @(posedge clk);
        model_edge(rst, bus.en, bus.we_IM, bus.codein, bus.immd);
        e.exp = fl_m; e.has_k = use_k; e.k = k; e.name = name;
        sb.push_back(e);
        #1;
    endtask

    task automatic load(input logic [31:0] code);
        bus.we_IM = 1'b1;
        bus.codein = code;
        tick("load", 0, 5'b0);
        bus.we_IM = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick("reset", 1, 5'b00000);
        tick("reset", 1, 5'b00000);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_entry_t e;
            logic [4:0] act;
            e = sb.pop_front();
            act = {bus.za, bus.zb, bus.eq, bus.gt, bus.lt};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s model flags: got %b expected %b", e.name, act, e.exp);
            end
            if (e.has_k) begin
                checks++;
                if (act !== e.k) begin
                    errors++;
                    $display("FAIL %s fixed flags: got %b expected %b", e.name, act, e.k);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.we_IM = 1'b0; bus.codein = 32'h0; bus.immd = 12'h0;
        do_reset();

        bus.en = 1'b1;
        repeat (20) tick("empty_im", 1, 5'b00000);

        // CMP R0,R0 then JMP 0
        do_reset();
        bus.en = 1'b0;
        load(32'h6000); load(32'hC000);
        bus.en = 1'b1;
        repeat (6) tick("cmp_zero", 1, 5'b11100);

        // LDI R1 / CMP R1,R0 / JMP 1
        do_reset();
        bus.en = 1'b0;
        load(32'h7111); load(32'h6010); load(32'hC001);
        bus.immd = 12'hFEB; bus.en = 1'b1;
        tick("ldi", 1, 5'b00000);
        tick("cmp_r1_r0", 1, 5'b01010);
        tick("jmp_hold", 1, 5'b01010);

        do_reset();
        bus.en = 1'b0;
        load(32'h7111); load(32'h6001); load(32'hC001);
        bus.en = 1'b1;
        tick("ldi", 0, 5'b0);
        tick("cmp_r0_r1", 1, 5'b10001);

        // ALU wrap-around
        do_reset();
        bus.en = 1'b0;
        load(32'h7100); load(32'h7200); load(32'h1312); load(32'h6030);
        load(32'h2421); load(32'h6042); load(32'hC006);
        bus.en = 1'b1;
        bus.immd = 12'hFFF; tick("ldi_fff", 0, 5'b0);
        bus.immd = 12'h001; tick("ldi_001", 0, 5'b0);
        tick("add_wrap", 1, 5'b00010);
        tick("cmp_r3_r0", 1, 5'b11100);
        tick("sub_wrap", 1, 5'b00001);
        tick("cmp_r4_r2", 1, 5'b00010);

        // Write stall while running
        bus.we_IM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.codein = 32'h6022;
            tick("stall", 1, 5'b00010);
        end
        bus.we_IM = 1'b0;
        repeat (4) tick("resume", 1, 5'b00010);

        // BEQ taken then not taken
        do_reset();
        bus.en = 1'b0;
        load(32'h7100); load(32'h6000); load(32'hD005); load(32'h6011); load(32'hC004);
        load(32'h6010); load(32'h6001); load(32'hD00A); load(32'h6000); load(32'hC009);
        load(32'h6011);
        bus.immd = 12'hFEB; bus.en = 1'b1;
        tick("ldi", 0, 5'b0);
        tick("cmp_eq", 1, 5'b11100);
        tick("beq_taken", 1, 5'b11100);
        tick("at_addr5", 1, 5'b01010);
        tick("cmp_ne", 1, 5'b10001);
        tick("beq_not", 1, 5'b10001);
        tick("fallthru", 1, 5'b11100);

        // Randomized programs with random control
        for (int r = 0; r < 30; r++) begin
            do_reset();
            bus.en = 1'b0;
            for (int i = 0; i < 16; i++) load($urandom());
            for (int c = 0; c < 60; c++) begin
                rst        = ($urandom_range(0, 199) == 0);
                bus.en     = ($urandom_range(0, 3) != 0);
                bus.we_IM  = ($urandom_range(0, 19) == 0);
                bus.codein = $urandom();
                bus.immd   = 12'($urandom());
                tick("random", 0, 5'b0);
            end
            rst = 1'b0; bus.we_IM = 1'b0;
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Minimal single-cycle 12-bit CPU with a loadable instruction memory (IM), a 16-entry register file, an ALU and a registered flag set (za, zb, eq, gt, lt).
- The program is streamed in through codein/we_IM.
- Execution runs while en is high; immediates come from the external immd port.
- Used as a standalone processing block; flags are its only observable outputs.

Parameters:
- DATA_W, 12, register/ALU width; must equal the immd width.
- IM_DEPTH, 16, instruction memory words (power of 2); PC and write pointer are log2(IM_DEPTH) bits.
- NREGS, 16, register file entries (4-bit register fields).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  execution enable.
- we_IM  in  1  instruction-memory write strobe.
- codein  in  32  instruction word to write; only bits [15:0] are decoded.
- immd  in  12  immediate operand for LDI.
- za  out  1  flag: R[ra]==0.
- zb  out  1  flag: R[rb]==0.
- eq  out  1  flag: R[ra]==R[rb].
- gt  out  1  flag: R[ra]>R[rb], unsigned.
- lt  out  1  flag: R[ra]<R[rb], unsigned.

Behaviour:
- Instruction format [15:0]: op=[15:12], rd=[11:8], ra=[7:4], rb=[3:0]. Bits [31:16] are stored but ignored.
- Reset (synchronous, priority over everything): PC=0, write pointer WP=0, all registers=0, all IM words=0 (NOP), all flags=0.
- IM load:
  - On a rising edge with we_IM=1, IM[WP]<=codein and WP<=WP+1, wrapping at IM_DEPTH.
  - we_IM=1 stalls execution in that cycle (PC, registers and flags hold), regardless of en.
  - One write per clock edge sampled high.
- Execute:
  - On a rising edge with en=1 and we_IM=0, the instruction at IM[PC] is executed completely in that edge.
  - Register/flag results are visible after that edge.
  - PC<=PC+1 (wrapping) unless a jump is taken.
  - en=0: full hold.
- Opcodes (all arithmetic mod 2^12; sources are read before the update):
  - 0 NOP.
  - 1 ADD rd=ra+rb.
  - 2 SUB rd=ra-rb.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 CMP: flags only, no register write.
  - 7 LDI rd=immd, with immd sampled at the executing edge.
  - 8 MOV rd=ra.
  - 9 SHL rd=ra<<1.
  - A SHR rd=ra>>1 (logical).
  - B NOT rd=~ra.
  - C JMP: PC<=instr[log2(IM_DEPTH)-1:0].
  - D BEQ: PC<=instr[log2(IM_DEPTH)-1:0] if the current eq flag=1, else PC+1.
  - E, F: NOP.
- Flag update:
  - Opcodes 1–6 and 8–B load all five flags from the pre-update R[ra] and R[rb] values.
  - NOP, LDI, JMP and BEQ hold the flags.
  - Exactly one of eq/gt/lt is 1 after any flag update.
- Register 0 is an ordinary writable register.
- Simultaneous we_IM and en: the write wins and execution stalls.
- Writing IM at the address currently addressed by PC is legal; the new word executes when PC next reaches that address.
- Reset mid-program: everything returns to the reset state, so the program must be reloaded.

Test Plan:
- Reset check: assert rst 2 cycles -> za=zb=eq=gt=lt=0; with en=1 and an empty IM (NOPs), flags stay 0 for 20 cycles.
- Load and compare zero: en=0, write 0x6000 at addr0 and 0xC000 at addr1; then en=1 -> after the first executed edge za=1, zb=1, eq=1, gt=0, lt=0; the program loops and the flags stay constant.
- LDI then CMP: load 0x7111 (LDI R1), 0x6010 (CMP R1,R0), 0xC001; immd=12'hFEB; en=1 -> after 2 execute edges gt=1, eq=0, lt=0, za=0, zb=1. Then CMP R0,R1 (0x6001) gives lt=1, za=1, zb=0.
- ALU wrap: LDI R1=0xFFF, LDI R2=0x001, ADD R3=R1+R2 (0x1312), CMP R3,R0 (0x6030) -> eq=1, za=1 (R3=0). SUB R4=R2-R1 (0x2421), then CMP R4,R2 (0x6042) -> R4=0x002, gt=1.
- Write-stall priority: while executing a loop, hold we_IM=1 for 3 edges -> PC and flags frozen, WP advances by 3; execution resumes with the next instruction after we_IM drops.
- BEQ/JMP: after CMP R0,R0 (eq=1), BEQ to addr5, where addr5 holds CMP R1,R0 with R1=0xFEB -> gt=1. With eq=0 the branch falls through to PC+1.
